// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32IM-style execute unit with a 2-cycle multiplier and a
// 1-bit-per-cycle restoring divider behind a valid/ready handshake.
// Ports: clk, rst (sync, active-high), in_valid/in_ready, operand1/operand2,
//   opcode/funct3/funct7, in_tag, flush, out_valid/out_ready,
//   out_result, out_tag, out_zero (out_result == 0).
module alu_exec_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_zero
);
    localparam int W   = DATA_WIDTH;
    localparam int SHW = $clog2(W);
    localparam int CW  = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    state_e         state_q;
    logic [2*W-1:0] prod_q;
    logic           mul_hi_q;
    logic [W-1:0]   rem_q, quo_q, dvs_q;
    logic [CW-1:0]  cnt_q;
    logic           qneg_q, rneg_q, isrem_q;
    logic           out_valid_q, out_zero_q;
    logic [W-1:0]   out_result_q;
    logic [TAG_WIDTH-1:0] out_tag_q;

    op_e op_d;

    // Instruction decode
    always_comb begin
        op_d = OP_ADD;
        if (opcode == 7'b0110011) begin
            if (funct7 == 7'h01) begin
                case (funct3)
                    3'd0: op_d = OP_MUL;
                    3'd1: op_d = OP_MULH;
                    3'd2: op_d = OP_MULHSU;
                    3'd3: op_d = OP_MULHU;
                    3'd4: op_d = OP_DIV;
                    3'd5: op_d = OP_DIVU;
                    3'd6: op_d = OP_REM;
                    3'd7: op_d = OP_REMU;
                endcase
            end else if (funct7 == 7'h00 || funct7 == 7'h20) begin
                case (funct3)
                    3'd0: op_d = (funct7 == 7'h20) ? OP_SUB : OP_ADD;
                    3'd1: op_d = OP_SLL;
                    3'd2: op_d = OP_SLT;
                    3'd3: op_d = OP_SLTU;
                    3'd4: op_d = OP_XOR;
                    3'd5: op_d = (funct7 == 7'h20) ? OP_SRA : OP_SRL;
                    3'd6: op_d = OP_OR;
                    3'd7: op_d = OP_AND;
                endcase
            end
        end else if (opcode == 7'b0010011) begin
            case (funct3)
                3'd0: op_d = OP_ADD;
                3'd1: op_d = OP_SLL;
                3'd2: op_d = OP_SLT;
                3'd3: op_d = OP_SLTU;
                3'd4: op_d = OP_XOR;
                3'd5: op_d = operand2[10] ? OP_SRA : OP_SRL;
                3'd6: op_d = OP_OR;
                3'd7: op_d = OP_AND;
            endcase
        end
    end

    // Single-cycle ALU
    logic [SHW-1:0] shamt;
    logic [W-1:0]   alu_res_d;
    assign shamt = operand2[SHW-1:0];

    always_comb begin
        case (op_d)
            OP_SUB:  alu_res_d = operand1 - operand2;
            OP_SLL:  alu_res_d = operand1 << shamt;
            OP_SLT:  alu_res_d = {{(W-1){1'b0}},
                                  $signed(operand1) < $signed(operand2)};
            OP_SLTU: alu_res_d = {{(W-1){1'b0}}, operand1 < operand2};
            OP_XOR:  alu_res_d = operand1 ^ operand2;
            OP_SRL:  alu_res_d = operand1 >> shamt;
            OP_SRA:  alu_res_d = $signed(operand1) >>> shamt;
            OP_OR:   alu_res_d = operand1 | operand2;
            OP_AND:  alu_res_d = operand1 & operand2;
            default: alu_res_d = operand1 + operand2;
        endcase
    end

    // Multiplier: sign-extend to 2W so one unsigned multiply covers all forms
    logic           mul_op, a_sx, b_sx;
    logic [2*W-1:0] ma_d, mb_d, prod_d;
    assign mul_op = op_d inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    assign a_sx   = (op_d == OP_MULH || op_d == OP_MULHSU) && operand1[W-1];
    assign b_sx   = (op_d == OP_MULH) && operand2[W-1];
    assign ma_d   = {{W{a_sx}}, operand1};
    assign mb_d   = {{W{b_sx}}, operand2};
    assign prod_d = ma_d * mb_d;

    // Divider setup and special cases
    logic         div_op, rem_op, sdiv_op, dz, ovf, a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag, spec_res;
    assign div_op  = op_d inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign rem_op  = (op_d == OP_REM) || (op_d == OP_REMU);
    assign sdiv_op = (op_d == OP_DIV) || (op_d == OP_REM);
    assign dz      = (operand2 == '0);
    assign ovf     = sdiv_op && (operand1 == {1'b1, {(W-1){1'b0}}})
                     && (&operand2);
    assign a_neg   = sdiv_op && operand1[W-1];
    assign b_neg   = sdiv_op && operand2[W-1];
    assign a_mag   = a_neg ? -operand1 : operand1;
    assign b_mag   = b_neg ? -operand2 : operand2;
    assign spec_res = dz ? (rem_op ? operand1 : '1)
                         : (rem_op ? '0 : operand1);

    // One restoring step; a negative trial keeps the shifted remainder
    logic [W:0]   trial_d;
    logic [W-1:0] rem_d, quo_d, q_fix, r_fix, div_res_d;
    assign trial_d   = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};
    assign rem_d     = trial_d[W] ? {rem_q[W-2:0], quo_q[W-1]}
                                  : trial_d[W-1:0];
    assign quo_d     = {quo_q[W-2:0], ~trial_d[W]};
    assign q_fix     = qneg_q ? -quo_d : quo_d;
    assign r_fix     = rneg_q ? -rem_d : rem_d;
    assign div_res_d = isrem_q ? r_fix : q_fix;

    logic [W-1:0] mul_res_d;
    assign mul_res_d = mul_hi_q ? prod_q[2*W-1:W] : prod_q[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prod_q       <= '0;
            mul_hi_q     <= 1'b0;
            rem_q        <= '0;
            quo_q        <= '0;
            dvs_q        <= '0;
            cnt_q        <= '0;
            qneg_q       <= 1'b0;
            rneg_q       <= 1'b0;
            isrem_q      <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_zero_q   <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    out_tag_q <= in_tag;
                    if (div_op && (dz || ovf)) begin
                        state_q      <= DONE;
                        out_valid_q  <= 1'b1;
                        out_result_q <= spec_res;
                        out_zero_q   <= (spec_res == '0);
                    end else if (div_op) begin
                        state_q <= DIV;
                        rem_q   <= '0;
                        quo_q   <= a_mag;
                        dvs_q   <= b_mag;
                        cnt_q   <= CW'(W);
                        qneg_q  <= a_neg ^ b_neg;
                        rneg_q  <= a_neg;
                        isrem_q <= rem_op;
                    end else if (mul_op) begin
                        state_q  <= MUL;
                        prod_q   <= prod_d;
                        mul_hi_q <= (op_d != OP_MUL);
                    end else begin
                        state_q      <= DONE;
                        out_valid_q  <= 1'b1;
                        out_result_q <= alu_res_d;
                        out_zero_q   <= (alu_res_d == '0);
                    end
                end
                MUL: begin
                    state_q      <= DONE;
                    out_valid_q  <= 1'b1;
                    out_result_q <= mul_res_d;
                    out_zero_q   <= (mul_res_d == '0);
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q      <= DONE;
                        out_valid_q  <= 1'b1;
                        out_result_q <= div_res_d;
                        out_zero_q   <= (div_res_d == '0);
                    end
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE) && !flush && !rst;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign out_zero   = out_zero_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: vector table + scoreboard bench for alu_exec_unit,
// with hand sequences for back-pressure, flush and reset.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] operand1, operand2, out_result;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [5:0]  in_tag, out_tag;
    logic        out_zero;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .operand1(operand1), .operand2(operand2), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_zero(out_zero)
    );

    typedef struct {
        string       nm;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a, b;
        logic [5:0]  tag;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  tag;
        int          lat;
    } exp_t;

    localparam logic [6:0] R = 7'b0110011;
    localparam logic [6:0] I = 7'b0010011;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic add(input string nm, input logic [6:0] opc,
                       input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag, input logic [31:0] res,
                       input int lat);
        vec_t v;
        v.nm = nm; v.opc = opc; v.f3 = f3; v.f7 = f7;
        v.a = a; v.b = b; v.tag = tag; v.res = res; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        opcode = v.opc; funct3 = v.f3; funct7 = v.f7;
        operand1 = v.a; operand2 = v.b; in_tag = v.tag;
        in_valid = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        exp_t e;
        @(negedge clk);
        drive(v);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({v.nm, "_accept"}, {31'd0, in_ready}, 32'd1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back('{v.res, v.tag, v.lat});
        #1 in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        chk({v.nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (!out_valid) return;
        chk({v.nm, "_lat"}, 32'(n), 32'(e.lat));
        chk({v.nm, "_res"}, out_result, e.res);
        chk({v.nm, "_tag"}, {26'd0, out_tag}, {26'd0, e.tag});
        chk({v.nm, "_zero"}, {31'd0, out_zero}, {31'd0, e.res == 0});
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        logic seen;

        add("add0",   R, 3'd0, 7'h00, 32'd7, -32'sd7, 6'd5, 32'd0, 1);
        add("sltu",   R, 3'd3, 7'h00, 32'd1, 32'hFFFFFFFF, 6'd1, 32'd1, 1);
        add("slt",    R, 3'd2, 7'h00, 32'd1, 32'hFFFFFFFF, 6'd2, 32'd0, 1);
        add("mulh",   R, 3'd1, 7'h01, 32'h80000000, 32'd2, 6'd3,
            32'hFFFFFFFF, 2);
        add("mulhu",  R, 3'd3, 7'h01, 32'h80000000, 32'd2, 6'd4, 32'd1, 2);
        add("div",    R, 3'd4, 7'h01, -32'sd20, 32'd6, 6'd6,
            32'hFFFFFFFD, 33);
        add("rem",    R, 3'd6, 7'h01, -32'sd20, 32'd6, 6'd7,
            32'hFFFFFFFE, 33);
        add("divu0",  R, 3'd5, 7'h01, 32'd123, 32'd0, 6'd8,
            32'hFFFFFFFF, 1);
        add("divovf", R, 3'd4, 7'h01, 32'h80000000, 32'hFFFFFFFF, 6'd9,
            32'h80000000, 1);
        add("removf", R, 3'd6, 7'h01, 32'h80000000, 32'hFFFFFFFF, 6'd10,
            32'd0, 1);
        add("sub",    R, 3'd0, 7'h20, 32'd5, 32'd9, 6'd11, 32'hFFFFFFFC, 1);
        add("sra",    R, 3'd5, 7'h20, 32'h80000000, 32'd4, 6'd12,
            32'hF8000000, 1);
        add("srl",    R, 3'd5, 7'h00, 32'h80000000, 32'd4, 6'd13,
            32'h08000000, 1);
        add("srai",   I, 3'd5, 7'h20, 32'h80000000, 32'h404, 6'd14,
            32'hF8000000, 1);
        add("sll",    R, 3'd1, 7'h00, 32'd3, 32'h21, 6'd15, 32'd6, 1);
        add("mul",    R, 3'd0, 7'h01, 32'hFFFFFFFF, 32'd3, 6'd16,
            32'hFFFFFFFD, 2);
        add("mulhsu", R, 3'd2, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd17,
            32'hFFFFFFFF, 2);
        add("divu",   R, 3'd5, 7'h01, 32'd100, 32'd7, 6'd18, 32'd14, 33);
        add("remu",   R, 3'd7, 7'h01, 32'd100, 32'd7, 6'd19, 32'd2, 33);
        add("remneg", R, 3'd6, 7'h01, 32'd20, -32'sd6, 6'd20, 32'd2, 33);
        add("divneg", R, 3'd4, 7'h01, 32'd20, -32'sd6, 6'd21,
            32'hFFFFFFFD, 33);
        add("unk",    7'd0, 3'd4, 7'h00, 32'd3, 32'd4, 6'd22, 32'd7, 1);
        add("xor",    R, 3'd4, 7'h00, 32'hF0F0, 32'hFF00, 6'd23,
            32'h0FF0, 1);
        add("or",     R, 3'd6, 7'h00, 32'hF0F0, 32'hFF00, 6'd24,
            32'hFFF0, 1);
        add("and",    R, 3'd7, 7'h00, 32'hF0F0, 32'hFF00, 6'd25,
            32'hF000, 1);
        add("remu0",  R, 3'd7, 7'h01, 32'd55, 32'd0, 6'd26, 32'd55, 1);
        add("addi",   I, 3'd0, 7'h20, 32'd5, 32'd9, 6'd27, 32'd14, 1);
        add("sltiu",  I, 3'd3, 7'h00, 32'd1, 32'hFFFFFFFF, 6'd28, 32'd1, 1);

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        opcode = '0; funct3 = '0; funct7 = '0;
        operand1 = '0; operand2 = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_tag", {26'd0, out_tag}, 32'd0);
        chk("rst_zero", {31'd0, out_zero}, 32'd0);
        rst = 1'b0;
        #1 chk("rst_ready", {31'd0, in_ready}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // back-pressure
        out_ready = 1'b0;
        @(negedge clk);
        v = vecs[0];
        v.nm = "bp"; v.a = 32'd1; v.b = 32'd2; v.tag = 6'd9;
        drive(v);
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_res", out_result, 32'd3);
            chk("bp_tag", {26'd0, out_tag}, 32'd9);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_drop", {31'd0, out_valid}, 32'd0);
        chk("bp_idle", {31'd0, in_ready}, 32'd1);

        // flush during divide iteration 10
        @(negedge clk);
        v = vecs[5];
        v.a = 32'd1000; v.b = 32'd3; v.tag = 6'd3;
        drive(v);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        #1 chk("fl_noaccept", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        #1;
        chk("fl_ready", {31'd0, in_ready}, 32'd1);
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        chk("fl_never", {31'd0, seen}, 32'd0);
        run_vec(vecs[17]);

        // reset mid-divide
        @(negedge clk);
        drive(vecs[5]);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rm_valid", {31'd0, out_valid}, 32'd0);
        chk("rm_result", out_result, 32'd0);
        chk("rm_tag", {26'd0, out_tag}, 32'd0);
        chk("rm_zero", {31'd0, out_zero}, 32'd0);
        chk("rm_ready_in_rst", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1 chk("rm_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        chk("rm_never", {31'd0, seen}, 32'd0);
        run_vec(vecs[3]);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
